// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter: two FIFO-buffered sources share one registered regfile write port.
// Optional macro RF_WB_PENDMASK_EN adds the pend_mask output (pending destination registers).
module rf_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              idle
`ifdef RF_WB_PENDMASK_EN
  ,
  output logic [(1<<ADDR_W)-1:0] pend_mask
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Index 0 is source A, index 1 is source B.
  logic [ADDR_W-1:0] addr_q [2][DEPTH];
  logic [DATA_W-1:0] data_q [2][DEPTH];
  logic [PTR_W-1:0]  wptr_q [2];
  logic [PTR_W-1:0]  wptr_d [2];
  logic [PTR_W-1:0]  rptr_q [2];
  logic [PTR_W-1:0]  rptr_d [2];
  logic [CNT_W-1:0]  cnt_q  [2];
  logic [CNT_W-1:0]  cnt_d  [2];
  logic              last_q, last_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic [1:0]        valid_s, ready_s, push_s, pop_s, nonempty_s;
  logic [ADDR_W-1:0] in_addr_s [2];
  logic [DATA_W-1:0] in_data_s [2];
  logic              gnt_v_s, gnt_src_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;

  always_comb begin
    valid_s      = {b_valid, a_valid};
    in_addr_s[0] = a_addr;
    in_addr_s[1] = b_addr;
    in_data_s[0] = a_data;
    in_data_s[1] = b_data;
    for (int s = 0; s < 2; s++) begin
      nonempty_s[s] = (cnt_q[s] != {CNT_W{1'b0}});
      ready_s[s]    = rdy_in & (cnt_q[s] != FULL);
      push_s[s]     = valid_s[s] & ready_s[s];
    end
  end

  // Contention goes to the source that did not win last; otherwise the only non-empty one.
  always_comb begin
    gnt_v_s = rdy_in & (|nonempty_s);
    if (nonempty_s == 2'b11) begin
      gnt_src_s = ~last_q;
    end else begin
      gnt_src_s = nonempty_s[1];
    end
    head_addr_s = addr_q[gnt_src_s][rptr_q[gnt_src_s]];
    head_data_s = data_q[gnt_src_s][rptr_q[gnt_src_s]];
    pop_s = 2'b00;
    if (gnt_v_s) begin
      pop_s[gnt_src_s] = 1'b1;
    end else begin
      pop_s = 2'b00;
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      wptr_d[s] = push_s[s] ? wptr_q[s] + PTR_W'(1) : wptr_q[s];
      rptr_d[s] = pop_s[s]  ? rptr_q[s] + PTR_W'(1) : rptr_q[s];
      cnt_d[s]  = cnt_q[s] + CNT_W'(push_s[s]) - CNT_W'(pop_s[s]);
    end
    if (gnt_v_s) begin
      last_d     = gnt_src_s;
      rf_we_d    = (head_addr_s != {ADDR_W{1'b0}});
      rf_waddr_d = head_addr_s;
      rf_wdata_d = head_data_s;
    end else begin
      last_d     = last_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= {PTR_W{1'b0}};
        rptr_q[s] <= {PTR_W{1'b0}};
        cnt_q[s]  <= {CNT_W{1'b0}};
      end
      last_q     <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= {ADDR_W{1'b0}};
      rf_wdata_q <= {DATA_W{1'b0}};
    end else begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= wptr_d[s];
        rptr_q[s] <= rptr_d[s];
        cnt_q[s]  <= cnt_d[s];
        if (push_s[s]) begin
          addr_q[s][wptr_q[s]] <= in_addr_s[s];
          data_q[s][wptr_q[s]] <= in_data_s[s];
        end
      end
      last_q     <= last_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign a_ready  = ready_s[0];
  assign b_ready  = ready_s[1];
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign idle     = ~nonempty_s[0] & ~nonempty_s[1] & ~rf_we_q;

`ifdef RF_WB_PENDMASK_EN
  logic [PTR_W-1:0] off_s;

  // An entry is occupied when its distance from the read pointer is below the count.
  always_comb begin
    pend_mask = {(1<<ADDR_W){1'b0}};
    off_s     = {PTR_W{1'b0}};
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        off_s = PTR_W'(i) - rptr_q[s];
        pend_mask[addr_q[s][i]] = pend_mask[addr_q[s][i]] | (CNT_W'(off_s) < cnt_q[s]);
      end
    end
    pend_mask[rf_waddr_q] = pend_mask[rf_waddr_q] | rf_we_q;
    pend_mask[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (DEPTH=2); pend_mask checks when RF_WB_PENDMASK_EN is defined.
module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, rf_we, idle;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
`ifdef RF_WB_PENDMASK_EN
  logic [(1<<AW)-1:0] pend_mask;
`endif

  rf_wb_arbiter #(.DEPTH(2), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .idle(idle)
`ifdef RF_WB_PENDMASK_EN
    , .pend_mask(pend_mask)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    step();
    rst_in = 1'b0;
  endtask

  logic [AW-1:0] sa_addr [8];
  logic [AW-1:0] sb_addr [8];
  int na, nb, nobs;
  logic [AW-1:0] obs_addr [32];
  logic [DW-1:0] obs_data [32];
  int obs_cyc [32];
  bit b_stalled;

  function automatic logic [DW-1:0] a_word(input logic [AW-1:0] ad);
    return 32'hA000_0000 | {27'd0, ad};
  endfunction

  function automatic logic [DW-1:0] b_word(input logic [AW-1:0] ad);
    return 32'hB000_0000 | {27'd0, ad};
  endfunction

  // Handshake-respecting driver plus write monitor.
  task automatic run(input int cycles);
    int ai, bi;
    logic ra, rb;
    ai = 0; bi = 0; nobs = 0; b_stalled = 1'b0;
    for (int c = 1; c <= cycles; c++) begin
      a_valid = (ai < na);
      b_valid = (bi < nb);
      if (ai < na) begin a_addr = sa_addr[ai]; a_data = a_word(sa_addr[ai]); end
      else begin a_addr = '0; a_data = '0; end
      if (bi < nb) begin b_addr = sb_addr[bi]; b_data = b_word(sb_addr[bi]); end
      else begin b_addr = '0; b_data = '0; end
      ra = a_ready; rb = b_ready;
      if (b_valid && !rb) b_stalled = 1'b1;
      step();
      if (a_valid && ra) ai++;
      if (b_valid && rb) bi++;
      if (rf_we && nobs < 32) begin
        obs_addr[nobs] = rf_waddr; obs_data[nobs] = rf_wdata; obs_cyc[nobs] = c; nobs++;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  int exp2 [6] = '{1, 9, 2, 10, 3, 11};
  int exp3 [8] = '{1, 17, 2, 18, 3, 19, 4, 20};

  initial begin
    // Reset state and single A write latency.
    do_reset();
    check_eq("rst_a_ready", a_ready, 1); check_eq("rst_b_ready", b_ready, 1);
    check_eq("rst_idle", idle, 1); check_eq("rst_we", rf_we, 0);
    check_eq("rst_waddr", rf_waddr, 0); check_eq("rst_wdata", rf_wdata, 0);
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1111_1111;
    step();
    a_valid = 1'b0;
    check_eq("t1_e1_we", rf_we, 0); check_eq("t1_e1_idle", idle, 0);
    step();
    check_eq("t1_e2_we", rf_we, 1); check_eq("t1_e2_waddr", rf_waddr, 5);
    check_eq("t1_e2_wdata", rf_wdata, 32'h1111_1111);
    step();
    check_eq("t1_e3_we", rf_we, 0); check_eq("t1_e3_idle", idle, 1);

    // Continuous contention alternates A and B with no gaps.
    do_reset();
    na = 3; nb = 3;
    sa_addr[0] = 5'd1; sa_addr[1] = 5'd2; sa_addr[2] = 5'd3;
    sb_addr[0] = 5'd9; sb_addr[1] = 5'd10; sb_addr[2] = 5'd11;
    run(10);
    check_eq("t2_nwrites", nobs, 6);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t2_addr%0d", i), obs_addr[i], exp2[i]);
      check_eq($sformatf("t2_cyc%0d", i), obs_cyc[i], 2 + i);
    end
    check_eq("t2_data0", obs_data[0], 32'hA000_0001);
    check_eq("t2_data1", obs_data[1], 32'hB000_0009);
    check_eq("t2_idle", idle, 1);

    // B backpressure while A saturates; nothing lost, order kept.
    do_reset();
    na = 4; nb = 4;
    for (int i = 0; i < 4; i++) begin
      sa_addr[i] = 5'(1 + i);
      sb_addr[i] = 5'(17 + i);
    end
    run(12);
    check_eq("t3_b_stalled", b_stalled, 1);
    check_eq("t3_nwrites", nobs, 8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t3_addr%0d", i), obs_addr[i], exp3[i]);
    end
    check_eq("t3_last_cyc", obs_cyc[7], 9);

    // Write to x0 is consumed silently; next write follows a cycle later.
    do_reset();
    na = 2; nb = 0;
    sa_addr[0] = 5'd0; sa_addr[1] = 5'd6;
    run(6);
    check_eq("t4_nwrites", nobs, 1);
    check_eq("t4_addr", obs_addr[0], 6);
    check_eq("t4_cyc", obs_cyc[0], 3);

    // rdy_in low freezes the block, then both entries drain A first.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h0000_0C0C;
    b_valid = 1'b1; b_addr = 5'd13; b_data = 32'h0000_0D0D;
    step();
    a_valid = 1'b0; b_valid = 1'b0; rdy_in = 1'b0;
    #1;
    check_eq("t5_a_ready_frz", a_ready, 0); check_eq("t5_b_ready_frz", b_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("t5_frz_we%0d", i), rf_we, 0);
      check_eq($sformatf("t5_frz_idle%0d", i), idle, 0);
    end
    rdy_in = 1'b1;
    #1;
    check_eq("t5_a_ready", a_ready, 1); check_eq("t5_b_ready", b_ready, 1);
    step();
    check_eq("t5_we0", rf_we, 1); check_eq("t5_addr0", rf_waddr, 12);
    check_eq("t5_data0", rf_wdata, 32'h0000_0C0C);
    step();
    check_eq("t5_we1", rf_we, 1); check_eq("t5_addr1", rf_waddr, 13);
    step();
    check_eq("t5_we2", rf_we, 0); check_eq("t5_idle", idle, 1);

    // Mid-operation reset discards queued writes.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd14; b_valid = 1'b1; b_addr = 5'd15;
    step();
    a_addr = 5'd16; b_valid = 1'b0;
    step();
    a_valid = 1'b0; rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check_eq("t6_idle", idle, 1); check_eq("t6_we", rf_we, 0);
    check_eq("t6_waddr", rf_waddr, 0); check_eq("t6_b_ready", b_ready, 1);
    step();
    check_eq("t6_we_after", rf_we, 0);
    step();
    check_eq("t6_we_after2", rf_we, 0);

`ifdef RF_WB_PENDMASK_EN
    do_reset();
    check_eq("pm_rst", pend_mask, 0);
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h7;
    step();
    a_valid = 1'b0;
    check_eq("pm_queued", pend_mask, 32'h0000_0080);
    step();
    check_eq("pm_out_we", rf_we, 1);
    check_eq("pm_out", pend_mask, 32'h0000_0080);
    step();
    check_eq("pm_clear", pend_mask, 0);
    a_valid = 1'b1; a_addr = 5'd3; b_valid = 1'b1; b_addr = 5'd4;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    check_eq("pm_two", pend_mask, 32'h0000_0018);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check_eq("pm_rst2", pend_mask, 0);
    check_eq("pm_rst2_idle", idle, 1);
    check_eq("pm_rst2_we", rf_we, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
